reg_file_v3: RTL and testbench

REG_FILE_V3 -- requirements
Module: reg_file_v3

---
 rtl/reg_file_v3.sv | 131 +++++++++++++
 tb/tb_reg_file_v3.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_v3.sv
// reg_file_v3: register file with a per-register busy (scoreboard) bit.
// Two combinational read ports with write-through bypass, one write port
// (writeback, clears busy) and one reserve port (issue, sets busy).
// Register 0 is hard-wired to zero and can never be reserved.
// BusyCnt tracks how many registers are currently busy. WrErr latches
// any writeback that targets a register that had no reservation.
module reg_file_v3 #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    output logic            Busy1,
    output logic            Busy2,
    input  logic [AW-1:0]   A3,
    input  logic [XLEN-1:0] WriteData,
    input  logic            WE,
    input  logic            RsvValid,
    input  logic [AW-1:0]   RsvAddr,
    output logic [AW:0]     BusyCnt,
    output logic            WrErr
);

    // Architectural state
    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic [AW:0]      busy_cnt_q;
    logic [AW:0]      busy_cnt_next;
    logic             wr_err_q;

    // Qualified request strobes; address 0 is never a legal target
    logic write_hit;
    logic rsv_hit;
    logic write_unreserved;

    // Decode the write and reserve requests, ignoring register 0
    always_comb begin
        write_hit        = WE && (A3 != '0);
        rsv_hit          = RsvValid && (RsvAddr != '0);
        write_unreserved = write_hit && !busy[A3];
    end

    // Next busy vector: writeback clears first, then a reservation sets,
    // so a same-edge reserve of the written register leaves it busy
    always_comb begin
        busy_next = busy;
        if (write_hit) begin
            busy_next[A3] = 1'b0;
        end
        if (rsv_hit) begin
            busy_next[RsvAddr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Population count of the next busy vector, registered as BusyCnt
    always_comb begin
        busy_cnt_next = '0;
        for (int i = 0; i < NREGS; i++) begin
            busy_cnt_next = busy_cnt_next + (AW+1)'(busy_next[i]);
        end
    end

    // Data storage: async clear, writeback on the rising edge
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_hit) begin
            regs[A3] <= WriteData;
        end
    end

    // Busy bits, busy count and sticky write-error flag
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            busy       <= '0;
            busy_cnt_q <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            busy       <= busy_next;
            busy_cnt_q <= busy_cnt_next;
            if (write_unreserved) begin
                wr_err_q <= 1'b1;
            end
        end
    end

    // Read port 1: bypass the in-flight write, register 0 reads zero
    always_comb begin
        if (write_hit && (A3 == A1)) begin
            RD1 = WriteData;
        end else if (A1 == '0) begin
            RD1 = '0;
        end else begin
            RD1 = regs[A1];
        end
    end

    // Read port 2: same rules as port 1
    always_comb begin
        if (write_hit && (A3 == A2)) begin
            RD2 = WriteData;
        end else if (A2 == '0) begin
            RD2 = '0;
        end else begin
            RD2 = regs[A2];
        end
    end

    // Busy status: a same-cycle writeback hides the bit, a same-cycle
    // reservation is only visible after the edge
    always_comb begin
        Busy1 = busy[A1] && !(WE && (A3 == A1));
        Busy2 = busy[A2] && !(WE && (A3 == A2));
    end

    // Registered status outputs
    always_comb begin
        BusyCnt = busy_cnt_q;
        WrErr   = wr_err_q;
    end

endmodule

// File: tb/tb_reg_file_v3.sv
// tb_reg_file_v3: directed test of reg_file_v3 against a behavioural model
// (register array, busy bit vector, sticky error) checked every cycle,
// plus hand-computed literal expectations at the interesting points.
module tb_reg_file_v3;

    logic        Clk;
    logic        Rst_n;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic        Busy1;
    logic        Busy2;
    logic [4:0]  A3;
    logic [31:0] WriteData;
    logic        WE;
    logic        RsvValid;
    logic [4:0]  RsvAddr;
    logic [5:0]  BusyCnt;
    logic        WrErr;

    int checks = 0;
    int passes = 0;
    bit cmp_en = 0;

    // Behavioural model state
    logic [31:0] m_regs [32];
    bit   [31:0] m_busy;
    bit          m_err;
    bit          m_wr;

    reg_file_v3 dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .A1        (A1),
        .A2        (A2),
        .RD1       (RD1),
        .RD2       (RD2),
        .Busy1     (Busy1),
        .Busy2     (Busy2),
        .A3        (A3),
        .WriteData (WriteData),
        .WE        (WE),
        .RsvValid  (RsvValid),
        .RsvAddr   (RsvAddr),
        .BusyCnt   (BusyCnt),
        .WrErr     (WrErr)
    );

    initial Clk = 0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [4:0] a3, input logic [31:0] wd,
                                 input logic rv, input logic [4:0] ra,
                                 input logic [4:0] a1, input logic [4:0] a2);
        @(posedge Clk);
        #1;
        WE = we; A3 = a3; WriteData = wd;
        RsvValid = rv; RsvAddr = ra;
        A1 = a1; A2 = a2;
    endtask

    task automatic waitSample();
        @(negedge Clk);
        #1;
    endtask

    // Model update: reserve sets, writeback stores data and clears busy,
    // a write to a non-reserved register raises the sticky error
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_busy = 32'd0;
            m_err  = 1'b0;
        end else begin
            m_wr = WE && (A3 != 5'd0);
            if (m_wr && !m_busy[A3]) m_err = 1'b1;
            if (m_wr) begin
                m_regs[A3] = WriteData;
                m_busy[A3] = 1'b0;
            end
            if (RsvValid && (RsvAddr != 5'd0)) m_busy[RsvAddr] = 1'b1;
        end
    end

    function automatic logic [31:0] expRead(input logic [4:0] a);
        if (WE && (A3 == a) && (a != 5'd0)) return WriteData;
        if (a == 5'd0) return 32'd0;
        return m_regs[a];
    endfunction

    function automatic logic expBusy(input logic [4:0] a);
        return (a != 5'd0) && m_busy[a] && !(WE && (A3 == a));
    endfunction

    // Per-cycle comparison of every output against the model
    always @(negedge Clk) begin
        if (cmp_en) begin
            checkOutput("model_rd1",   RD1, expRead(A1));
            checkOutput("model_rd2",   RD2, expRead(A2));
            checkOutput("model_busy1", {31'd0, Busy1}, {31'd0, expBusy(A1)});
            checkOutput("model_busy2", {31'd0, Busy2}, {31'd0, expBusy(A2)});
            checkOutput("model_cnt",   {26'd0, BusyCnt}, $countones(m_busy));
            checkOutput("model_err",   {31'd0, WrErr}, {31'd0, m_err});
        end
    end

    initial begin
        Rst_n = 1; WE = 0; A3 = 0; WriteData = 0; RsvValid = 0; RsvAddr = 0; A1 = 0; A2 = 0;
        #2 Rst_n = 0;
        cmp_en = 1;
        @(posedge Clk);
        @(negedge Clk);
        #2 Rst_n = 1;

        // Power-up reads
        applyStimulus(0, 0, 0, 0, 0, 5, 0);
        waitSample();
        checkOutput("por_rd1",   RD1, 32'd0);
        checkOutput("por_rd2",   RD2, 32'd0);
        checkOutput("por_busy1", {31'd0, Busy1}, 32'd0);
        checkOutput("por_cnt",   {26'd0, BusyCnt}, 32'd0);
        checkOutput("por_err",   {31'd0, WrErr}, 32'd0);

        // Reserve 7: not visible in the same cycle
        applyStimulus(0, 0, 0, 1, 7, 7, 0);
        waitSample();
        checkOutput("rsv7_same_busy1", {31'd0, Busy1}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 7, 0);
        waitSample();
        checkOutput("rsv7_busy1", {31'd0, Busy1}, 32'd1);
        checkOutput("rsv7_cnt",   {26'd0, BusyCnt}, 32'd1);
        // Writeback with bypass and busy hidden in the same cycle
        applyStimulus(1, 7, 32'hDEADBEEF, 0, 0, 7, 0);
        waitSample();
        checkOutput("wb7_bypass", RD1, 32'hDEADBEEF);
        checkOutput("wb7_busy1",  {31'd0, Busy1}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 7, 7);
        waitSample();
        checkOutput("wb7_rd2", RD2, 32'hDEADBEEF);
        checkOutput("wb7_cnt", {26'd0, BusyCnt}, 32'd0);
        checkOutput("wb7_err", {31'd0, WrErr}, 32'd0);

        // Register 0 ignores writes and reservations
        applyStimulus(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
        waitSample();
        checkOutput("r0_nobypass", RD1, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        waitSample();
        checkOutput("r0_rd1", RD1, 32'd0);
        checkOutput("r0_cnt", {26'd0, BusyCnt}, 32'd0);
        checkOutput("r0_err", {31'd0, WrErr}, 32'd0);

        // Same-edge reserve and write of a busy register 9
        applyStimulus(0, 0, 0, 1, 9, 0, 9);
        applyStimulus(1, 9, 32'h12, 1, 9, 0, 9);
        waitSample();
        checkOutput("r9_same_busy2", {31'd0, Busy2}, 32'd0);
        checkOutput("r9_same_rd2",   RD2, 32'h12);
        applyStimulus(0, 0, 0, 0, 0, 0, 9);
        waitSample();
        checkOutput("r9_rd2",   RD2, 32'h12);
        checkOutput("r9_busy2", {31'd0, Busy2}, 32'd1);
        checkOutput("r9_cnt",   {26'd0, BusyCnt}, 32'd1);
        checkOutput("r9_err",   {31'd0, WrErr}, 32'd0);
        // Reserving an already-busy register keeps the count
        applyStimulus(0, 0, 0, 1, 9, 0, 9);
        applyStimulus(0, 0, 0, 0, 0, 0, 9);
        waitSample();
        checkOutput("r9_rersv_cnt", {26'd0, BusyCnt}, 32'd1);

        // Unreserved write raises the sticky error
        applyStimulus(1, 4, 32'h44, 0, 0, 4, 0);
        applyStimulus(0, 0, 0, 0, 0, 4, 0);
        waitSample();
        checkOutput("err_set", {31'd0, WrErr}, 32'd1);
        checkOutput("err_rd1", RD1, 32'h44);
        applyStimulus(1, 9, 32'h99, 0, 0, 9, 0);
        applyStimulus(0, 0, 0, 0, 0, 9, 0);
        waitSample();
        checkOutput("err_sticky", {31'd0, WrErr}, 32'd1);
        checkOutput("err_cnt",    {26'd0, BusyCnt}, 32'd0);
        checkOutput("err_rd9",    RD1, 32'h99);

        // Three reservations, then an asynchronous reset between edges
        applyStimulus(0, 0, 0, 1, 3, 0, 0);
        applyStimulus(0, 0, 0, 1, 4, 0, 0);
        applyStimulus(0, 0, 0, 1, 5, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 3, 5);
        waitSample();
        checkOutput("three_cnt",   {26'd0, BusyCnt}, 32'd3);
        checkOutput("three_busy1", {31'd0, Busy1}, 32'd1);
        A1 = 4; A2 = 7;
        #1 Rst_n = 0;
        #1;
        checkOutput("arst_cnt",   {26'd0, BusyCnt}, 32'd0);
        checkOutput("arst_rd1",   RD1, 32'd0);
        checkOutput("arst_rd2",   RD2, 32'd0);
        checkOutput("arst_err",   {31'd0, WrErr}, 32'd0);
        A1 = 3;
        #0;
        checkOutput("arst_busy1", {31'd0, Busy1}, 32'd0);

        // While held in reset only the bypass path is visible
        applyStimulus(1, 6, 32'h66, 1, 6, 6, 2);
        waitSample();
        checkOutput("inrst_bypass", RD1, 32'h66);
        checkOutput("inrst_rd2",    RD2, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 6, 0);
        waitSample();
        #1 Rst_n = 1;
        applyStimulus(0, 0, 0, 0, 0, 6, 0);
        waitSample();
        checkOutput("post_rd6", RD1, 32'd0);
        checkOutput("post_cnt", {26'd0, BusyCnt}, 32'd0);
        applyStimulus(0, 0, 0, 1, 3, 3, 0);
        applyStimulus(0, 0, 0, 0, 0, 3, 0);
        waitSample();
        checkOutput("post_rsv_cnt",   {26'd0, BusyCnt}, 32'd1);
        checkOutput("post_rsv_busy1", {31'd0, Busy1}, 32'd1);
        checkOutput("post_err",       {31'd0, WrErr}, 32'd0);

        cmp_en = 0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
